// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// IdExPipeReg (module id_ex_pipe_reg)
//
// ID/EX pipeline register. Captures register file read data and decoded
// instruction fields from the decode stage and presents them to execute.
// Also detects load-use hazards and inserts exactly one bubble per hazard.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : a write-back result aimed at a register being read this cycle
//               is forwarded into ex_rdat1/ex_rdat2. This is for a register
//               file that writes on posedge.
//   undefined : wb_* inputs are ignored and ex_rdat* take rdat* directly.
//               This is for a register file that writes on negedge.
//
// Parameters
//   CTRL_W         width of the opaque decoded control bundle
//
// Ports
//   CLK            clock, all state updates on posedge
//   nRST           asynchronous active-low reset
//   en             global advance (0 = hold all state)
//   flush          squash: load a bubble into EX (wins even over en=0)
//   id_*           decode-stage instruction fields
//   rsel1/rsel2    register file source selects
//   rdat1/rdat2    register file read data
//   wb_wen/wsel/wdat  write-back port (used only with RF_BYPASS_EN)
//   ex_*           latched execute-stage fields (all zero in a bubble)
//   loaduse_stall  combinational: hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int CTRL_W = 12
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_memread,
    input  logic              id_regwen,
    input  logic [4:0]        id_wsel,
    input  logic [4:0]        rsel1,
    input  logic [4:0]        rsel2,
    input  logic [31:0]       rdat1,
    input  logic [31:0]       rdat2,
    input  logic              wb_wen,
    input  logic [4:0]        wb_wsel,
    input  logic [31:0]       wb_wdat,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_instr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_memread,
    output logic              ex_regwen,
    output logic [4:0]        ex_wsel,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [31:0]       ex_rdat1,
    output logic [31:0]       ex_rdat2,
    output logic [31:0]       ex_imm,
    output logic              loaduse_stall
);

    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_instr;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_memread;
    logic              r_regwen;
    logic [4:0]        r_wsel;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [31:0]       r_rdat1;
    logic [31:0]       r_rdat2;
    logic [31:0]       r_imm;

    logic              w_stall;
    logic [31:0]       w_opA;
    logic [31:0]       w_opB;
    logic [31:0]       w_immExt;

    // A load in EX whose destination is read by the real instruction in ID
    // cannot be forwarded in time. $0 is never a hazard because it is
    // hard-wired. Only registered state and ID inputs are involved, so the
    // stall drops as soon as the bubble clears r_memread (or on reset).
    assign w_stall = r_valid & r_memread & (r_wsel != 5'd0) & id_valid
                   & ((r_wsel == rsel1) | (r_wsel == rsel2));

    assign w_immExt = {{16{id_instr[15]}}, id_instr[15:0]};

`ifdef RF_BYPASS_EN
    // The register file writes on posedge, so a same-cycle write-back is not
    // yet visible on rdat*. Forward it here.
    assign w_opA = (wb_wen && (wb_wsel != 5'd0) && (wb_wsel == rsel1)) ? wb_wdat : rdat1;
    assign w_opB = (wb_wen && (wb_wsel != 5'd0) && (wb_wsel == rsel2)) ? wb_wdat : rdat2;
`else
    // The register file writes on negedge, so rdat* already carries the
    // write-back value. The wb_* port is intentionally unused in this build.
    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, wb_wen, wb_wsel, wb_wdat};
    assign w_opA = rdat1;
    assign w_opB = rdat2;
`endif

    // Priority: flush > hold (!en) > load-use bubble > capture.
    // A bubble is the all-zero state, identical to reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST || flush || (en && w_stall)) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_ctrl    <= '0;
            r_memread <= 1'b0;
            r_regwen  <= 1'b0;
            r_wsel    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rdat1   <= '0;
            r_rdat2   <= '0;
            r_imm     <= '0;
        end else if (en) begin
            // An invalid ID slot still carries its fields along, but must not
            // write a register or look like a load to the hazard logic.
            r_valid   <= id_valid;
            r_pc      <= id_pc;
            r_instr   <= id_instr;
            r_ctrl    <= id_ctrl;
            r_memread <= id_memread & id_valid;
            r_regwen  <= id_regwen & id_valid;
            r_wsel    <= id_wsel;
            r_rs      <= rsel1;
            r_rt      <= rsel2;
            r_rdat1   <= w_opA;
            r_rdat2   <= w_opB;
            r_imm     <= w_immExt;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_instr      = r_instr;
    assign ex_ctrl       = r_ctrl;
    assign ex_memread    = r_memread;
    assign ex_regwen     = r_regwen;
    assign ex_wsel       = r_wsel;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rdat1      = r_rdat1;
    assign ex_rdat2      = r_rdat2;
    assign ex_imm        = r_imm;
    assign loaduse_stall = w_stall;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// Directed testbench for id_ex_pipe_reg. Inputs change 2 time units after
// each rising edge and outputs are compared 1 unit after that.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

    localparam int CTRL_W = 12;

    logic              CLK;
    logic              nRST;
    logic              en;
    logic              flush;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [31:0]       id_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_memread;
    logic              id_regwen;
    logic [4:0]        id_wsel;
    logic [4:0]        rsel1;
    logic [4:0]        rsel2;
    logic [31:0]       rdat1;
    logic [31:0]       rdat2;
    logic              wb_wen;
    logic [4:0]        wb_wsel;
    logic [31:0]       wb_wdat;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_instr;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_memread;
    logic              ex_regwen;
    logic [4:0]        ex_wsel;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [31:0]       ex_rdat1;
    logic [31:0]       ex_rdat2;
    logic [31:0]       ex_imm;
    logic              loaduse_stall;

    int testCount = 0;
    int failCount = 0;

    id_ex_pipe_reg #(.CTRL_W(CTRL_W)) dut (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_ctrl(id_ctrl), .id_memread(id_memread), .id_regwen(id_regwen),
        .id_wsel(id_wsel), .rsel1(rsel1), .rsel2(rsel2),
        .rdat1(rdat1), .rdat2(rdat2),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_ctrl(ex_ctrl), .ex_memread(ex_memread), .ex_regwen(ex_regwen),
        .ex_wsel(ex_wsel), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2), .ex_imm(ex_imm),
        .loaduse_stall(loaduse_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one decode-stage instruction.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic [CTRL_W-1:0] ctrl,
                                 input logic mr, input logic rw, input logic [4:0] ws,
                                 input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [31:0] d1, input logic [31:0] d2);
        id_valid   = v;
        id_pc      = pc;
        id_instr   = instr;
        id_ctrl    = ctrl;
        id_memread = mr;
        id_regwen  = rw;
        id_wsel    = ws;
        rsel1      = s1;
        rsel2      = s2;
        rdat1      = d1;
        rdat2      = d2;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClock();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; en = 1'b1; flush = 1'b0;
        wb_wen = 1'b0; wb_wsel = '0; wb_wdat = '0;
        applyStimulus(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);

        // Reset state
        #2;
        checkOutput("rst_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("rst_pc", ex_pc, 32'h0);
        checkOutput("rst_stall", {31'b0, loaduse_stall}, 32'h0);
        nRST = 1'b1;
        stepClock();

        // Normal flow: add-like instruction, imm low half 0x4020
        applyStimulus(1'b1, 32'h40, 32'h012A4020, 12'h5A3, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 32'hA, 32'hB);
        checkOutput("norm_stall", {31'b0, loaduse_stall}, 32'h0);
        stepClock();
        checkOutput("norm_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("norm_pc", ex_pc, 32'h40);
        checkOutput("norm_instr", ex_instr, 32'h012A4020);
        checkOutput("norm_rdat1", ex_rdat1, 32'hA);
        checkOutput("norm_rdat2", ex_rdat2, 32'hB);
        checkOutput("norm_ctrl", {20'b0, ex_ctrl}, 32'h5A3);
        checkOutput("norm_wsel", {27'b0, ex_wsel}, 32'h3);
        checkOutput("norm_rs", {27'b0, ex_rs}, 32'h1);
        checkOutput("norm_rt", {27'b0, ex_rt}, 32'h2);
        checkOutput("norm_imm", ex_imm, 32'h00004020);
        checkOutput("norm_regwen", {31'b0, ex_regwen}, 32'h1);

        // Load-use: lw $8 enters EX, then add reading $8 sits in ID
        applyStimulus(1'b1, 32'h44, 32'h8C080004, 12'h011, 1'b1, 1'b1, 5'd8, 5'd1, 5'd8, 32'h1, 32'h2);
        stepClock();
        checkOutput("lw_memread", {31'b0, ex_memread}, 32'h1);
        applyStimulus(1'b1, 32'h48, 32'h01094820, 12'h022, 1'b0, 1'b1, 5'd9, 5'd8, 5'd10, 32'h111, 32'h222);
        checkOutput("lu_stall_on", {31'b0, loaduse_stall}, 32'h1);
        stepClock();
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("lu_bubble_pc", ex_pc, 32'h0);
        checkOutput("lu_bubble_regwen", {31'b0, ex_regwen}, 32'h0);
        checkOutput("lu_stall_off", {31'b0, loaduse_stall}, 32'h0);
        stepClock();
        checkOutput("lu_cap_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("lu_cap_pc", ex_pc, 32'h48);
        checkOutput("lu_cap_rdat1", ex_rdat1, 32'h111);
        checkOutput("lu_cap_rs", {27'b0, ex_rs}, 32'h8);

        // Priority: flush beats en=0
        applyStimulus(1'b1, 32'h4C, 32'h0, 12'h033, 1'b0, 1'b1, 5'd4, 5'd1, 5'd2, 32'h5, 32'h6);
        flush = 1'b1; en = 1'b0;
        stepClock();
        checkOutput("flush_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("flush_pc", ex_pc, 32'h0);
        flush = 1'b0; en = 1'b1;
        applyStimulus(1'b1, 32'h50, 32'h00001234, 12'h044, 1'b0, 1'b1, 5'd6, 5'd2, 5'd3, 32'h77, 32'h88);
        stepClock();
        checkOutput("pre_hold_pc", ex_pc, 32'h50);

        // Hold for three cycles while ID changes underneath
        en = 1'b0;
        applyStimulus(1'b1, 32'h54, 32'hFFFFFFFF, 12'hFFF, 1'b1, 1'b0, 5'd7, 5'd9, 5'd9, 32'h99, 32'hAA);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkOutput("hold_pc", ex_pc, 32'h50);
            checkOutput("hold_rdat2", ex_rdat2, 32'h88);
            checkOutput("hold_memread", {31'b0, ex_memread}, 32'h0);
        end
        en = 1'b1;

        // Load to $0 with negative immediate; no stall on a $0 reader
        applyStimulus(1'b1, 32'h58, 32'h8C008000, 12'h011, 1'b1, 1'b1, 5'd0, 5'd1, 5'd0, 32'h3, 32'h0);
        stepClock();
        checkOutput("neg_imm", ex_imm, 32'hFFFF8000);
        checkOutput("zero_ld_memread", {31'b0, ex_memread}, 32'h1);
        applyStimulus(1'b1, 32'h5C, 32'h00000000, 12'h022, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0);
        checkOutput("zero_no_stall", {31'b0, loaduse_stall}, 32'h0);

        // Invalid ID slot: control bits suppressed, other fields captured
        applyStimulus(1'b0, 32'h60, 32'h8C0A0010, 12'h055, 1'b1, 1'b1, 5'd10, 5'd4, 5'd5, 32'h1, 32'h2);
        stepClock();
        checkOutput("inv_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("inv_memread", {31'b0, ex_memread}, 32'h0);
        checkOutput("inv_regwen", {31'b0, ex_regwen}, 32'h0);
        checkOutput("inv_pc", ex_pc, 32'h60);

        // Write-back bypass on rsel2
        wb_wen = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h1234;
        applyStimulus(1'b1, 32'h64, 32'h00A52020, 12'h066, 1'b0, 1'b1, 5'd4, 5'd1, 5'd5, 32'hC, 32'h0);
        stepClock();
`ifdef RF_BYPASS_EN
        checkOutput("bypass_rdat2", ex_rdat2, 32'h1234);
`else
        checkOutput("bypass_rdat2", ex_rdat2, 32'h0);
`endif
        checkOutput("bypass_rdat1", ex_rdat1, 32'hC);
        wb_wen = 1'b0;

        // Reset asserted mid-stall drops everything asynchronously
        applyStimulus(1'b1, 32'h68, 32'h8C080000, 12'h011, 1'b1, 1'b1, 5'd8, 5'd0, 5'd8, 32'h0, 32'h0);
        stepClock();
        applyStimulus(1'b1, 32'h6C, 32'h01000000, 12'h022, 1'b0, 1'b1, 5'd9, 5'd8, 5'd0, 32'h0, 32'h0);
        checkOutput("rst_mid_stall_on", {31'b0, loaduse_stall}, 32'h1);
        nRST = 1'b0;
        #1;
        checkOutput("rst_mid_stall", {31'b0, loaduse_stall}, 32'h0);
        checkOutput("rst_mid_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("rst_mid_pc", ex_pc, 32'h0);
        checkOutput("rst_mid_memread", {31'b0, ex_memread}, 32'h0);
        nRST = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
